writeback_stage: RTL

Parametrised writeback stage for the pipelined RISC-V core. It combines the MEM/WB pipeline register with stall and flush control, a four-way result select, and load-data byte/halfword extraction with sign or zero extension. It sits between the memory stage and the register-file write port, and presents one qualified write per retired instruction.

---
 rtl/writeback_stage_if.sv | 45 ++++
 rtl/writeback_stage.sv | 107 ++++++++++
 2 files changed

// File: rtl/writeback_stage_if.sv
// Memory-to-writeback handshake bundle: M-side candidates and pipeline control in,
// qualified register-file write out. Optional retire counter behind WB_RETIRE_CNT_EN.
interface writeback_stage_if #(
   parameter int W  = 32,
   parameter int AW = 5
);
   logic          stallW;
   logic          flushW;
   logic          validM;
   logic          regwriteM;
   logic [AW-1:0] rdM;
   logic [1:0]    resultsrcM;
   logic [2:0]    funct3M;
   logic [1:0]    byteoffM;
   logic [W-1:0]  aluresultM;
   logic [W-1:0]  readdataM;
   logic [W-1:0]  pcplus4M;
   logic [W-1:0]  immextM;

   logic [W-1:0]  resultW;
   logic [AW-1:0] rdW;
   logic          regwriteW;
   logic          validW;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0]   instretW;
`endif

   modport master (
`ifdef WB_RETIRE_CNT_EN
      input  instretW,
`endif
      output stallW, flushW, validM, regwriteM, rdM, resultsrcM, funct3M, byteoffM,
      output aluresultM, readdataM, pcplus4M, immextM,
      input  resultW, rdW, regwriteW, validW
   );

   modport slave (
`ifdef WB_RETIRE_CNT_EN
      output instretW,
`endif
      input  stallW, flushW, validM, regwriteM, rdM, resultsrcM, funct3M, byteoffM,
      input  aluresultM, readdataM, pcplus4M, immextM,
      output resultW, rdW, regwriteW, validW
   );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with stall/flush, four-way result select and load formatting.
// Define WB_RETIRE_CNT_EN to add the 64-bit retired-instruction counter (instretW).
module writeback_stage #(
   parameter int W  = 32,
   parameter int AW = 5
) (
   input  logic           clk,
   input  logic           rst,
   writeback_stage_if.slave wb
);

   logic          valid_q;
   logic          regwrite_q;
   logic [AW-1:0] rd_q;
   logic [1:0]    resultsrc_q;
   logic [2:0]    funct3_q;
   logic [1:0]    byteoff_q;
   logic [W-1:0]  aluresult_q;
   logic [W-1:0]  readdata_q;
   logic [W-1:0]  pcplus4_q;
   logic [W-1:0]  immext_q;

   logic          load_en;
   logic [31:0]   ld_word;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [W-1:0]  load_val;
   logic [W-1:0]  result;

   // Flush takes priority over stall so a stalled slot can still be killed.
   assign load_en = !wb.flushW && !wb.stallW;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         regwrite_q  <= 1'b0;
         rd_q        <= '0;
         resultsrc_q <= '0;
         funct3_q    <= '0;
         byteoff_q   <= '0;
         aluresult_q <= '0;
         readdata_q  <= '0;
         pcplus4_q   <= '0;
         immext_q    <= '0;
      end else if (wb.flushW) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
      end else if (load_en) begin
         valid_q     <= wb.validM;
         regwrite_q  <= wb.regwriteM;
         rd_q        <= wb.rdM;
         resultsrc_q <= wb.resultsrcM;
         funct3_q    <= wb.funct3M;
         byteoff_q   <= wb.byteoffM;
         aluresult_q <= wb.aluresultM;
         readdata_q  <= wb.readdataM;
         pcplus4_q   <= wb.pcplus4M;
         immext_q    <= wb.immextM;
      end
   end

   // Halfword select ignores byteoff[0]; misaligned accesses never reach this stage.
   always_comb begin
      ld_word  = readdata_q[31:0];
      ld_byte  = ld_word[{byteoff_q, 3'b000} +: 8];
      ld_half  = ld_word[{byteoff_q[1], 4'b0000} +: 16];
      load_val = readdata_q;
      case (funct3_q)
         3'b000:  load_val = W'($signed(ld_byte));
         3'b001:  load_val = W'($signed(ld_half));
         3'b010:  load_val = W'($signed(ld_word));
         3'b100:  load_val = W'(ld_byte);
         3'b101:  load_val = W'(ld_half);
         default: load_val = readdata_q;
      endcase
   end

   always_comb begin
      result = aluresult_q;
      case (resultsrc_q)
         2'b00:   result = aluresult_q;
         2'b01:   result = load_val;
         2'b10:   result = pcplus4_q;
         default: result = immext_q;
      endcase
   end

   assign wb.resultW   = result;
   assign wb.rdW       = rd_q;
   assign wb.validW    = valid_q;
   assign wb.regwriteW = valid_q && regwrite_q && (rd_q != '0);

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] instret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_q <= '0;
      end else if (load_en && wb.validM) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign wb.instretW = instret_q;
`endif

endmodule
